// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg -- shared definitions for the instruction-memory boot loader.
//   SYNC_BYTE : frame start marker
//   LEN_W     : width of the word-count field that follows the sync byte
//   state_t   : loader FSM states (CHK exists only with IMEM_LOADER_CHECKSUM_EN)
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         LEN_W     = 16;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, WRITE, CHK, DONE, ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR
  } state_t;
`endif

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer -- collects four bytes into a little-endian 32-bit word.
//   clk, rst : clock, async active-low reset
//   en       : a byte is accepted this cycle
//   din      : byte value
//   word     : assembled word; the first byte of a group lands in [7:0]
//   full     : high in the cycle the 4th byte of a group is accepted
// The word register only shifts on en, so it holds steady while the
// parent issues the memory write.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        full
);

  logic [1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
      cnt  <= '0;
    end else if (en) begin
      // newest byte enters at the top; after four shifts the first is at [7:0]
      word <= {din, word[31:8]};
      cnt  <= cnt + 2'd1;
    end
  end

  assign full = en && (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader -- receives a framed byte stream and writes it into an external
// instruction memory, holding the downstream core in reset until done.
// Frame: A5, len_lo, len_hi, N*4 data bytes [, xor checksum].
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (running XOR over length and
// data bytes, verified against one trailing byte).
// Ports:
//   clk, rst        : clock, async active-low reset
//   in_valid/in_data/in_ready : byte stream handshake
//   imem_we/imem_addr/imem_wdata : instruction-memory write port
//   core_rst_n      : core hold, released only on a good load
//   done, error     : load outcome
//   words_loaded    : words written so far
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [31:0] CAP = 32'd1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FIN = CHK;
`else
  localparam state_t FIN = DONE;
`endif

  state_t            st, nxt;
  logic              live;
  logic              acc;
  logic              pk_full;
  logic [31:0]       pk_word;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  n_in;
  logic [ADDR_W:0]   wl_inc;

  // live keeps in_ready low in reset and for the cycle before the first edge
  assign in_ready = live && (st != WRITE) && (st != DONE);
  assign acc      = in_valid && in_ready;
  assign n_in     = {in_data, len[7:0]};
  assign wl_inc   = words_loaded + 1'b1;

  byte_packer u_pack (
    .clk  (clk),
    .rst  (rst),
    .en   (acc && (st == DATA)),
    .din  (in_data),
    .word (pk_word),
    .full (pk_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st           <= IDLE;
      live         <= 1'b0;
      len          <= '0;
      words_loaded <= '0;
    end else begin
      st   <= nxt;
      live <= 1'b1;
      if (acc && (st == LEN0)) len[7:0]  <= in_data;
      if (acc && (st == LEN1)) len[15:8] <= in_data;
      if (st == WRITE)         words_loaded <= wl_inc;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      csum <= '0;
    else if (acc && ((st == LEN0) || (st == LEN1) || (st == DATA)))
      csum <= csum ^ in_data;
  end
`endif

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:  if (acc && (in_data == SYNC_BYTE)) nxt = LEN0;
      LEN0:  if (acc) nxt = LEN1;
      LEN1:
        if (acc) begin
          if (32'(n_in) > CAP)   nxt = ERR;
          else if (n_in == '0)   nxt = FIN;
          else                   nxt = DATA;
        end
      DATA:  if (pk_full) nxt = WRITE;
      WRITE: nxt = (32'(wl_inc) < 32'(len)) ? DATA : FIN;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:   if (acc) nxt = (in_data == csum) ? DONE : ERR;
`endif
      DONE:  nxt = DONE;
      ERR:   nxt = ERR;
      default: nxt = IDLE;
    endcase
  end

  // 32-bit modulo address; words_loaded is the index of the word in flight
  assign imem_we    = (st == WRITE);
  assign imem_addr  = BASE_ADDR + (32'(words_loaded) << 2);
  assign imem_wdata = pk_word;
  assign core_rst_n = (st == DONE);
  assign done       = (st == DONE);
  assign error      = (st == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- randomized self-checking bench for imem_loader.
// A stream builder produces framed byte streams; an independent parser
// derives the expected writes and outcome from the frame rules.
module tb_imem_loader;

  localparam int          ADDR_W = 8;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  typedef logic [ADDR_W:0] wl_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_ready, imem_we, core_rst_n, done, error;
  logic [31:0]      imem_addr, imem_wdata;
  logic [ADDR_W:0]  words_loaded;

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_rst_n(core_rst_n), .done(done),
    .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit both_seen = 0;
  logic [7:0]  stim[$];
  logic [31:0] obs_addr[$], obs_data[$], exp_addr[$], exp_data[$];
  int          obs_cyc[$];
  bit          exp_done, exp_err;
  int          exp_wl;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we) begin
      obs_addr.push_back(imem_addr);
      obs_data.push_back(imem_wdata);
      obs_cyc.push_back(cyc);
    end
    if (imem_we && done) both_seen = 1;
  end

  task automatic do_reset();
    in_valid = 0;
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    both_seen = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    if (gap > 0) begin
      in_valid = 0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1;
    in_data  = b;
    for (int t = 0; t < 40; t++) begin
      if (in_ready) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL in_ready_timeout byte %h got in_ready=0 want 1", b);
  endtask

  task automatic run_stream(input int maxgap);
    foreach (stim[i]) send_byte(stim[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    in_valid = 0;
    repeat (8) @(negedge clk);
  endtask

  // junk byte, sync, length field, ndata words, optional checksum byte
  task automatic mk_stream(input int n, input int ndata, input bit fixed, input bit bad_ck);
    logic [7:0]  x;
    logic [31:0] w;
    stim.delete();
    stim.push_back(8'h00);
    stim.push_back(8'hA5);
    stim.push_back(n[7:0]);
    stim.push_back(n[15:8]);
    x = n[7:0] ^ n[15:8];
    for (int k = 0; k < ndata; k++) begin
      w = fixed ? ((k == 0) ? 32'h0050_0013 : 32'h0010_0093) : $urandom;
      for (int j = 0; j < 4; j++) begin
        stim.push_back(w[8*j +: 8]);
        x ^= w[8*j +: 8];
      end
    end
    x = bad_ck ? ~x : x;
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim.push_back(x);
`endif
  endtask

  // Parse the stream by the frame rules to get expected writes and outcome
  task automatic model();
    int          i, n;
    logic [7:0]  x;
    logic [31:0] w;
    exp_addr.delete(); exp_data.delete();
    exp_done = 0; exp_err = 0; exp_wl = 0;
    i = 0;
    while (i < stim.size() && stim[i] != 8'hA5) i++;
    i++;
    n = int'(stim[i]) + 256 * int'(stim[i+1]);
    x = stim[i] ^ stim[i+1];
    i += 2;
    if (n > (1 << ADDR_W)) begin
      exp_err = 1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      w = {stim[i+3], stim[i+2], stim[i+1], stim[i]};
      x ^= stim[i] ^ stim[i+1] ^ stim[i+2] ^ stim[i+3];
      exp_addr.push_back(BASE + 32'(4 * k));
      exp_data.push_back(w);
      i += 4;
    end
    exp_wl = n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (stim[i] == x) exp_done = 1; else exp_err = 1;
`else
    exp_done = 1;
`endif
  endtask

  // index of first write disagreement, -1 when all agree
  function automatic int bad_write();
    int m;
    m = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int k = 0; k < m; k++)
      if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k]) return k;
    return (obs_addr.size() != exp_addr.size()) ? m : -1;
  endfunction

  function automatic string wdesc(input int k);
    if (k < obs_addr.size() && k < exp_addr.size())
      return $sformatf("got %h@%h want %h@%h", obs_data[k], obs_addr[k], exp_data[k], exp_addr[k]);
    return $sformatf("got %0d writes want %0d", obs_addr.size(), exp_addr.size());
  endfunction

  task automatic test_reset();
    rst = 0;
    #1;
    checks++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, done, error, words_loaded} !==
        {1'b0, 1'b0, BASE, 32'h0, 1'b0, 1'b0, 1'b0, wl_t'(0)}) begin
      errors++;
      $display("FAIL reset_vals got rdy=%b we=%b a=%h d=%h crn=%b dn=%b er=%b wl=%0d want all idle",
               in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, done, error, words_loaded);
    end
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge got %b want 1", in_ready); end
  endtask

  task automatic test_load(input string name, input int n, input int ndata,
                           input bit fixed, input bit bad_ck, input int maxgap);
    int k;
    do_reset();
    mk_stream(n, ndata, fixed, bad_ck);
    model();
    run_stream(maxgap);
    k = bad_write();
    checks++;
    if (k >= 0) begin errors++; $display("FAIL %s_writes idx %0d %s", name, k, wdesc(k)); end
    checks++;
    if ({done, error, core_rst_n, words_loaded, both_seen} !==
        {exp_done, exp_err, exp_done, wl_t'(exp_wl), 1'b0}) begin
      errors++;
      $display("FAIL %s_status got dn=%b er=%b crn=%b wl=%0d both=%b want dn=%b er=%b crn=%b wl=%0d both=0",
               name, done, error, core_rst_n, words_loaded, both_seen,
               exp_done, exp_err, exp_done, exp_wl);
    end
  endtask

  task automatic test_basic();
    test_load("basic", 2, 2, 1, 0, 0);
    checks++;
    if (exp_data.size() != 2 || exp_data[0] !== 32'h0050_0013 || exp_data[1] !== 32'h0010_0093 ||
        exp_addr[1] !== 32'h4) begin
      errors++;
      $display("FAIL basic_model got %0d words want 00500013@0,00100093@4", exp_data.size());
    end
  endtask

  task automatic test_gaps();
    test_load("gaps", 2, 2, 1, 0, 7);
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 6);
      test_load($sformatf("rand%0d", r), n, n, 0, 0, 7);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    test_load("b2b", 5, 5, 0, 0, 0);
    bad = 0;
    for (int k = 1; k < obs_cyc.size(); k++)
      if (obs_cyc[k] - obs_cyc[k-1] != 5) bad++;
    checks++;
    if (bad != 0 || obs_cyc.size() != 5) begin
      errors++;
      $display("FAIL b2b_spacing got %0d bad gaps over %0d writes want 0 over 5", bad, obs_cyc.size());
    end
  endtask

  task automatic test_len_overflow();
    test_load("len257", 257, 3, 0, 0, 0);
  endtask

  task automatic test_len_zero();
    test_load("len0", 0, 0, 0, 0, 0);
  endtask

  task automatic test_max_len();
    test_load("len256", 256, 256, 0, 0, 0);
    checks++;
    if (obs_addr.size() != 256 || obs_addr[255] !== BASE + 32'h3FC) begin
      errors++;
      $display("FAIL len256_last got %0d writes want last @%h", obs_addr.size(), BASE + 32'h3FC);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum_err();
    test_load("badck", 2, 2, 1, 1, 0);
  endtask
`endif

  task automatic test_reset_mid();
    int k;
    do_reset();
    mk_stream(2, 2, 1, 0);
    for (int i = 0; i < 10; i++) send_byte(stim[i], 0);
    in_valid = 0;
    rst = 0;
    #1;
    checks++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, done, error, words_loaded} !==
        {1'b0, 1'b0, BASE, 32'h0, 1'b0, 1'b0, 1'b0, wl_t'(0)}) begin
      errors++;
      $display("FAIL midrst_vals got rdy=%b we=%b a=%h d=%h crn=%b dn=%b er=%b wl=%0d want all idle",
               in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, done, error, words_loaded);
    end
    checks++;
    if (obs_data.size() != 1 || obs_data[0] !== 32'h0050_0013) begin
      errors++;
      $display("FAIL midrst_partial got %0d writes want 1 (00500013)", obs_data.size());
    end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    model();
    run_stream(0);
    k = bad_write();
    checks++;
    if (k >= 0) begin errors++; $display("FAIL midrst_writes idx %0d %s", k, wdesc(k)); end
    checks++;
    if ({done, core_rst_n, words_loaded} !== {1'b1, 1'b1, wl_t'(2)}) begin
      errors++;
      $display("FAIL midrst_status got dn=%b crn=%b wl=%0d want 1 1 2", done, core_rst_n, words_loaded);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_len_overflow();
    test_len_zero();
    test_max_len();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum_err();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
